// File: rtl/match_result_drain_pkg.sv
// Shared definitions for the string_match result reader: state encoding and default widths.
package match_result_drain_pkg;

  // 150 pattern positions, two result bits each, plus two status bits.
  localparam int DEF_RWIDTH = 150 * 2 + 2;
  localparam int DEF_IWIDTH = 9;
  localparam int DEF_CWIDTH = 9;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_LOAD = 2'd1,
    ST_EMIT = 2'd2
  } drain_state_t;

endpackage

// File: rtl/match_result_drain_lsb_encoder.sv
// Lowest-set-bit encoder: reports the index of the lowest set bit and the vector with it removed.
module lsb_encoder #(
  parameter int RWIDTH = 302,
  parameter int IWIDTH = 9
) (
  input  logic [RWIDTH-1:0] vec,
  output logic [IWIDTH-1:0] idx,
  output logic              any,
  output logic [RWIDTH-1:0] vec_clr
);

  localparam logic [RWIDTH-1:0] ONE = {{(RWIDTH-1){1'b0}}, 1'b1};

  assign any     = |vec;
  assign vec_clr = vec & (vec - ONE);

  // Scan downwards so the lowest set bit is the last one to write idx.
  always_comb begin
    idx = '0;
    for (int i = RWIDTH - 1; i >= 0; i--) begin
      if (vec[i]) idx = IWIDTH'(i);
    end
  end

endmodule

// File: rtl/match_result_drain.sv
// Snapshots the controller's match vector on done and drains it as ascending per-match index records.
module match_result_drain
  import match_result_drain_pkg::*;
#(
  parameter int RWIDTH = DEF_RWIDTH,
  parameter int IWIDTH = DEF_IWIDTH,
  parameter int CWIDTH = DEF_CWIDTH
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              done,
  input  logic [RWIDTH-1:0] result,
  output logic              cap_ready,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [IWIDTH-1:0] out_index,
  output logic              out_last,
  output logic              out_none,
  output logic [CWIDTH-1:0] out_count,
  output logic              overrun,
  input  logic              clr_ovr
);

  drain_state_t      state;
  logic [RWIDTH-1:0] shadow;
  logic [CWIDTH-1:0] cnt;

  logic [IWIDTH-1:0] low_idx;
  logic              low_any;
  logic [RWIDTH-1:0] shadow_clr;

  lsb_encoder #(.RWIDTH(RWIDTH), .IWIDTH(IWIDTH)) u_enc (
    .vec     (shadow),
    .idx     (low_idx),
    .any     (low_any),
    .vec_clr (shadow_clr)
  );

  assign cap_ready = (state == ST_IDLE);

  // A done that arrives while busy is dropped; the sticky flag records it and set beats clear.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      overrun <= 1'b0;
    end else if (done && state != ST_IDLE) begin
      overrun <= 1'b1;
    end else if (clr_ovr) begin
      overrun <= 1'b0;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state     <= ST_IDLE;
      shadow    <= '0;
      cnt       <= '0;
      out_valid <= 1'b0;
      out_index <= '0;
      out_last  <= 1'b0;
      out_none  <= 1'b0;
      out_count <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (done) begin
            shadow <= result;
            cnt    <= '0;
            state  <= ST_LOAD;
          end
        end
        ST_LOAD: begin
          out_valid <= 1'b1;
          state     <= ST_EMIT;
          if (!low_any) begin
            out_none  <= 1'b1;
            out_last  <= 1'b1;
            out_index <= '0;
            out_count <= '0;
          end else begin
            out_none  <= 1'b0;
            out_index <= low_idx;
            shadow    <= shadow_clr;
            out_last  <= (shadow_clr == '0);
            cnt       <= cnt + 1'b1;
            out_count <= cnt + 1'b1;
          end
        end
        ST_EMIT: begin
          // Next record is loaded on the same edge the current one is accepted.
          if (out_valid && out_ready) begin
            if (out_last) begin
              out_valid <= 1'b0;
              out_none  <= 1'b0;
              out_last  <= 1'b0;
              state     <= ST_IDLE;
            end else begin
              out_index <= low_idx;
              shadow    <= shadow_clr;
              out_last  <= (shadow_clr == '0);
              cnt       <= cnt + 1'b1;
              out_count <= cnt + 1'b1;
            end
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_match_result_drain.sv
// Randomized bench for match_result_drain against a bit-scan reference model of the record stream.
module tb_match_result_drain;
  import match_result_drain_pkg::*;

  localparam int RW = DEF_RWIDTH;
  localparam int IW = DEF_IWIDTH;
  localparam int CW = DEF_CWIDTH;

  typedef logic [RW-1:0] vec_t;

  logic          clk = 1'b0;
  logic          reset;
  logic          done;
  vec_t          result;
  logic          cap_ready;
  logic          out_valid;
  logic          out_ready;
  logic [IW-1:0] out_index;
  logic          out_last;
  logic          out_none;
  logic [CW-1:0] out_count;
  logic          overrun;
  logic          clr_ovr;

  always #5 clk = ~clk;

  match_result_drain dut (
    .clk       (clk),
    .reset     (reset),
    .done      (done),
    .result    (result),
    .cap_ready (cap_ready),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_index (out_index),
    .out_last  (out_last),
    .out_none  (out_none),
    .out_count (out_count),
    .overrun   (overrun),
    .clr_ovr   (clr_ovr)
  );

  int checks = 0;
  int failures = 0;

  int exp_q[$];
  int got_idx[$];
  int got_last[$];
  int got_none[$];
  int got_count;
  int stable_err;
  int gap_cycles;
  bit timed_out;

  // Reference: matches are simply the set bit positions, listed low to high.
  function automatic void build_expected(input vec_t v);
    exp_q.delete();
    for (int i = 0; i < RW; i++) if (v[i]) exp_q.push_back(i);
  endfunction

  function automatic vec_t random_vec(input int density);
    vec_t v;
    v = '0;
    for (int i = 0; i < RW; i++) v[i] = ($urandom_range(0, 99) < density);
    return v;
  endfunction

  // Presents one done pulse at a negedge; returns at the negedge after the capturing edge.
  task automatic send_frame(input vec_t v);
    result = v;
    done   = 1'b1;
    @(negedge clk);
    done   = 1'b0;
    result = random_vec(50);
  endtask

  // Accepts records until out_last, stalling each record for 'stall' cycles first.
  task automatic collect_frame(input int stall);
    int stall_cnt;
    bit seen;
    bit finished;
    logic [IW-1:0] h_idx;
    logic h_last, h_none;
    logic [CW-1:0] h_cnt;
    stall_cnt = 0; seen = 0; finished = 0;
    h_idx = '0; h_last = 0; h_none = 0; h_cnt = '0;
    got_idx.delete(); got_last.delete(); got_none.delete();
    got_count = -1; stable_err = 0; gap_cycles = 0; timed_out = 1;
    for (int c = 0; c < 4000; c++) begin
      if (out_valid) begin
        seen = 1;
        if (stall_cnt == 0) begin
          h_idx = out_index; h_last = out_last; h_none = out_none; h_cnt = out_count;
        end else if (out_index !== h_idx || out_last !== h_last ||
                     out_none !== h_none || out_count !== h_cnt) begin
          stable_err++;
        end
        if (stall_cnt < stall) begin
          out_ready = 1'b0;
          stall_cnt++;
        end else begin
          out_ready = 1'b1;
          got_idx.push_back(int'(out_index));
          got_last.push_back(int'(out_last));
          got_none.push_back(int'(out_none));
          if (out_last) begin
            got_count = int'(out_count);
            finished = 1;
          end
          stall_cnt = 0;
        end
      end else begin
        out_ready = 1'b0;
        if (seen) gap_cycles++;
      end
      @(negedge clk);
      if (finished) begin
        timed_out = 0;
        break;
      end
    end
    out_ready = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b0; done = 1'b0; result = '0; out_ready = 1'b0; clr_ovr = 1'b0;
    #12;
    checks++;
    if (out_valid !== 1'b0 || out_last !== 1'b0 || out_none !== 1'b0 || out_index !== '0 ||
        out_count !== '0 || overrun !== 1'b0 || cap_ready !== 1'b1) begin
      failures++;
      $display("[TB] FAIL reset_state: got valid=%b last=%b none=%b idx=%0d cnt=%0d ovr=%b cap=%b, want 0 0 0 0 0 0 1",
               out_valid, out_last, out_none, out_index, out_count, overrun, cap_ready);
    end
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_single_bit();
    vec_t v;
    v = '0; v[5] = 1'b1;
    send_frame(v);
    checks++;
    if (out_valid !== 1'b0) begin
      failures++;
      $display("[TB] FAIL single_latency_early: out_valid=%b want 0", out_valid);
    end
    @(negedge clk);
    checks++;
    if (out_valid !== 1'b1) begin
      failures++;
      $display("[TB] FAIL single_latency: out_valid=%b want 1", out_valid);
    end
    collect_frame(0);
    checks++;
    if (timed_out || got_idx.size() != 1 || got_idx[0] != 5 || got_last[0] != 1 ||
        got_none[0] != 0 || got_count != 1) begin
      failures++;
      $display("[TB] FAIL single_record: n=%0d idx=%0d last=%0d none=%0d cnt=%0d, want 1 5 1 0 1",
               got_idx.size(), got_idx.size() ? got_idx[0] : -1,
               got_last.size() ? got_last[0] : -1, got_none.size() ? got_none[0] : -1, got_count);
    end
  endtask

  task automatic test_three_bits(input int stall);
    vec_t v;
    int bad;
    v = '0; v[0] = 1'b1; v[7] = 1'b1; v[RW-1] = 1'b1;
    build_expected(v);
    send_frame(v);
    collect_frame(stall);
    bad = 0;
    for (int i = 0; i < exp_q.size(); i++) begin
      if (i >= got_idx.size()) bad++;
      else if (got_idx[i] != exp_q[i] || got_last[i] != int'(i == exp_q.size() - 1) || got_none[i] != 0) bad++;
    end
    checks++;
    if (timed_out || bad != 0 || got_idx.size() != 3) begin
      failures++;
      $display("[TB] FAIL three_order stall=%0d: n=%0d bad=%0d timeout=%0b, want n=3 bad=0", stall, got_idx.size(), bad, timed_out);
    end
    checks++;
    if (got_count != 3) begin
      failures++;
      $display("[TB] FAIL three_count stall=%0d: got %0d want 3", stall, got_count);
    end
    checks++;
    if (stable_err != 0 || gap_cycles != 0) begin
      failures++;
      $display("[TB] FAIL three_flow stall=%0d: unstable=%0d gaps=%0d want 0 0", stall, stable_err, gap_cycles);
    end
    checks++;
    if (cap_ready !== 1'b1) begin
      failures++;
      $display("[TB] FAIL three_cap_ready: got %b want 1", cap_ready);
    end
  endtask

  task automatic test_empty();
    send_frame('0);
    collect_frame(1);
    checks++;
    if (timed_out || got_idx.size() != 1 || got_idx[0] != 0 || got_none[0] != 1 ||
        got_last[0] != 1 || got_count != 0) begin
      failures++;
      $display("[TB] FAIL empty_frame: n=%0d idx=%0d none=%0d last=%0d cnt=%0d, want 1 0 1 1 0",
               got_idx.size(), got_idx.size() ? got_idx[0] : -1,
               got_none.size() ? got_none[0] : -1, got_last.size() ? got_last[0] : -1, got_count);
    end
  endtask

  task automatic test_overrun(input bit with_clear);
    vec_t a, b;
    int bad;
    a = random_vec(10); a[3] = 1'b1;
    b = ~a;
    build_expected(a);
    send_frame(a);
    @(negedge clk);
    result = b; done = 1'b1; clr_ovr = with_clear;
    @(negedge clk);
    done = 1'b0; clr_ovr = 1'b0;
    checks++;
    if (overrun !== 1'b1) begin
      failures++;
      $display("[TB] FAIL overrun_set clr=%0b: got %b want 1", with_clear, overrun);
    end
    collect_frame($urandom_range(0, 1));
    bad = 0;
    for (int i = 0; i < exp_q.size(); i++)
      if (i >= got_idx.size() || got_idx[i] != exp_q[i]) bad++;
    checks++;
    if (timed_out || bad != 0 || got_idx.size() != exp_q.size() || got_count != exp_q.size()) begin
      failures++;
      $display("[TB] FAIL overrun_frame: n=%0d cnt=%0d bad=%0d, want n=%0d cnt=%0d bad=0",
               got_idx.size(), got_count, bad, exp_q.size(), exp_q.size());
    end
    clr_ovr = 1'b1;
    @(negedge clk);
    clr_ovr = 1'b0;
    checks++;
    if (overrun !== 1'b0) begin
      failures++;
      $display("[TB] FAIL overrun_clear: got %b want 0", overrun);
    end
  endtask

  task automatic test_async_reset();
    vec_t v;
    int bad;
    v = random_vec(30); v[1] = 1'b1; v[2] = 1'b1;
    send_frame(v);
    @(negedge clk);
    @(negedge clk);
    #2 reset = 1'b0;
    #1;
    checks++;
    if (out_valid !== 1'b0 || out_last !== 1'b0 || out_none !== 1'b0 || out_index !== '0 ||
        out_count !== '0 || overrun !== 1'b0 || cap_ready !== 1'b1) begin
      failures++;
      $display("[TB] FAIL async_reset: valid=%b last=%b none=%b idx=%0d cnt=%0d ovr=%b cap=%b, want 0 0 0 0 0 0 1",
               out_valid, out_last, out_none, out_index, out_count, overrun, cap_ready);
    end
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    v = random_vec(5); v[RW-2] = 1'b1;
    build_expected(v);
    send_frame(v);
    collect_frame(0);
    bad = 0;
    for (int i = 0; i < exp_q.size(); i++)
      if (i >= got_idx.size() || got_idx[i] != exp_q[i]) bad++;
    checks++;
    if (timed_out || bad != 0 || got_idx.size() != exp_q.size() || got_count != exp_q.size()) begin
      failures++;
      $display("[TB] FAIL after_reset_frame: n=%0d cnt=%0d bad=%0d, want n=%0d bad=0",
               got_idx.size(), got_count, bad, exp_q.size());
    end
  endtask

  task automatic test_random_frames();
    vec_t v;
    int bad;
    for (int f = 0; f < 16; f++) begin
      v = random_vec($urandom_range(0, 3) == 0 ? 0 : $urandom_range(1, 20));
      build_expected(v);
      send_frame(v);
      collect_frame($urandom_range(0, 2));
      bad = 0;
      if (exp_q.size() == 0) begin
        if (got_idx.size() != 1 || got_idx[0] != 0 || got_none[0] != 1 || got_last[0] != 1) bad++;
      end else begin
        for (int i = 0; i < exp_q.size(); i++) begin
          if (i >= got_idx.size()) bad++;
          else if (got_idx[i] != exp_q[i] || got_none[i] != 0 ||
                   got_last[i] != int'(i == exp_q.size() - 1)) bad++;
        end
        if (got_idx.size() != exp_q.size()) bad++;
      end
      checks++;
      if (timed_out || bad != 0 || got_count != exp_q.size() || stable_err != 0) begin
        failures++;
        $display("[TB] FAIL random_frame %0d: n=%0d cnt=%0d bad=%0d unstable=%0d timeout=%0b, want n=%0d cnt=%0d",
                 f, got_idx.size(), got_count, bad, stable_err, timed_out,
                 exp_q.size() == 0 ? 1 : exp_q.size(), exp_q.size());
      end
    end
  endtask

  initial begin
    test_reset();
    test_single_bit();
    test_three_bits(0);
    test_three_bits(4);
    test_empty();
    test_overrun(1'b0);
    test_overrun(1'b1);
    test_async_reset();
    test_random_frames();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
